// File: rtl/interp_fir8_pipe.sv
// 8-tap 1/16-sample luma interpolation filter: sliding window, shift-add products,
// two partial sums, then round/shift/clip, all stalling together on output backpressure.
module interp_fir8_pipe #(
    parameter int IN_W      = 10,
    parameter int SHIFT     = 6,
    parameter int CLIP      = 1,
    parameter int FRAC_BITS = 4,
    localparam int OUT_W    = (CLIP != 0) ? IN_W : IN_W + 8 - SHIFT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sol,
    input  logic [IN_W-1:0]      in_data,
    input  logic [FRAC_BITS-1:0] in_frac,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data
);
    localparam int ACC_W = IN_W + 8;
    localparam int R_W   = ACC_W - SHIFT;
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1 << (SHIFT - 1));
    localparam logic signed [R_W-1:0]   RMAX = R_W'((1 << IN_W) - 1);

    // Half table; rows 9..15 are the tap-reversed mirrors of rows 7..1.
    localparam int COEF [9][8] = '{
        '{ 0, 0,   0, 64,  0,   0, 0,  0},
        '{ 0, 1,  -3, 63,  4,  -2, 1,  0},
        '{-1, 2,  -5, 62,  8,  -3, 1,  0},
        '{-1, 3,  -8, 60, 13,  -4, 1,  0},
        '{-1, 4, -10, 58, 17,  -5, 1,  0},
        '{-1, 4, -11, 52, 26,  -8, 3, -1},
        '{-1, 3,  -9, 47, 31, -10, 4, -1},
        '{-1, 4, -11, 45, 34, -10, 4, -1},
        '{-1, 4, -11, 40, 40, -11, 4, -1}
    };

    function automatic logic [ACC_W-1:0] shadd(input logic [IN_W-1:0] x, input logic [7:0] c);
        logic [6:0]       mag;
        logic [ACC_W-1:0] acc;
        mag = c[7] ? 7'(-c) : c[6:0];
        acc = '0;
        for (int b = 0; b < 7; b++)
            if (mag[b]) acc = acc + (ACC_W'(x) << b);
        return c[7] ? -acc : acc;
    endfunction

    logic [7:0][IN_W-1:0]  w;
    logic [2:0]            fill;
    logic [FRAC_BITS-1:0]  frac0;
    logic [3:0]            vld_pipe;
    logic [7:0][ACC_W-1:0] prod, p1;
    logic [1:0][ACC_W-1:0] p2;
    logic                  stall, accept, issue, rev;
    logic [3:0]            ridx;
    logic signed [ACC_W-1:0] sum, rnd;
    logic signed [R_W-1:0]   r;
    logic [OUT_W-1:0]        res;

    assign out_valid = vld_pipe[3];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign issue     = accept && (fill == 3'd7) && !in_sol;

    assign rev  = frac0 > 4'd8;
    assign ridx = rev ? 4'(5'd16 - 5'(frac0)) : 4'(frac0);

    for (genvar k = 0; k < 8; k++) begin : g_tap
        logic [7:0] c;
        assign c       = rev ? 8'(COEF[ridx][7-k]) : 8'(COEF[ridx][k]);
        assign prod[k] = shadd(w[k], c);
    end

    assign sum = p2[0] + p2[1];
    assign rnd = sum + RND;
    assign r   = R_W'(rnd >>> SHIFT);

    if (CLIP != 0) begin : g_clip
        always_comb begin
            if (r < 0)          res = '0;
            else if (r > RMAX)  res = '1;
            else                res = OUT_W'(r);
        end
    end else begin : g_noclip
        assign res = OUT_W'(r);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w        <= '0;
            fill     <= '0;
            frac0    <= '0;
            vld_pipe <= '0;
            p1       <= '0;
            p2       <= '0;
            out_data <= '0;
        end else if (!stall) begin
            if (accept) begin
                w     <= {in_data, w[7:1]};
                frac0 <= in_frac;
                fill  <= in_sol ? 3'd0 : ((fill == 3'd7) ? fill : fill + 3'd1);
            end
            vld_pipe <= {vld_pipe[2:0], issue};
            p1       <= prod;
            p2[0]    <= p1[0] + p1[1] + p1[2] + p1[3];
            p2[1]    <= p1[4] + p1[5] + p1[6] + p1[7];
            out_data <= res;
        end
    end
endmodule

// File: tb/tb_interp_fir8_pipe.sv
// Directed bench for interp_fir8_pipe: pass-through, filter vector table, backpressure,
// line restart and mid-stream reset.
module tb_interp_fir8_pipe;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, in_sol = 1'b0, out_ready = 1'b1;
    logic [9:0] in_data = '0;
    logic [3:0] in_frac = '0;
    logic       in_ready, out_valid;
    logic [9:0] out_data;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int got[$];
    int got_cyc[$];

    typedef int win_t [8];
    typedef struct { win_t w; int frac; int exp; } vec_t;
    vec_t vt[$];

    interp_fir8_pipe #(.IN_W(10), .SHIFT(6), .CLIP(1), .FRAC_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sol(in_sol), .in_data(in_data), .in_frac(in_frac),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (out_valid && out_ready) begin
            got.push_back(int'(out_data));
            got_cyc.push_back(cyc);
        end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int d, input int f, input bit sol);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 10'(d); in_frac = 4'(f); in_sol = sol;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stuck at %0d, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sol = 1'b0;
    endtask

    task automatic wait_n(input int n);
        int t = 0;
        while (got.size() < n && t < 200) begin @(negedge clk); t++; end
        if (got.size() < n) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_outputs: got %0d results, expected %0d", got.size(), n);
        end
    endtask

    task automatic add(input win_t a, input int f, input int e);
        vec_t v;
        v.w = a; v.frac = f; v.exp = e;
        vt.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc8;
        int hold;
        win_t tw;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        // Pass-through at frac 0: output is w[3], 3-cycle latency, 1/cycle
        acc8 = 0;
        for (int i = 1; i <= 20; i++) begin
            send(i, 0, 1'b0);
            if (i == 8) acc8 = cyc;
        end
        wait_n(13);
        repeat (5) @(negedge clk);
        check("pass_count", got.size(), 13);
        if (got.size() >= 13) begin
            check("pass_latency", got_cyc[0] - acc8, 3);
            for (int i = 0; i < 13; i++) begin
                check($sformatf("pass_val[%0d]", i), got[i], 4 + i);
                check($sformatf("pass_cyc[%0d]", i), got_cyc[i] - got_cyc[0], i);
            end
        end

        // Filter vector table; each vector is sol + 8 window samples
        for (int f = 0; f < 16; f++) begin
            tw = '{512, 512, 512, 512, 512, 512, 512, 512};
            add(tw, f, 512);
        end
        tw = '{0, 0, 0, 0, 1023, 1023, 1023, 1023};       add(tw, 4, 208);
        tw = '{1023, 1023, 1023, 1023, 0, 0, 0, 0};       add(tw, 12, 208);
        tw = '{0, 1023, 0, 1023, 1023, 0, 1023, 0};       add(tw, 8, 1023);
        tw = '{1023, 0, 1023, 0, 0, 1023, 0, 1023};       add(tw, 8, 0);
        tw = '{0, 10, 20, 30, 40, 50, 60, 70};            add(tw, 1, 31);
        tw = '{0, 10, 20, 30, 40, 50, 60, 70};            add(tw, 8, 35);
        tw = '{0, 10, 20, 30, 40, 50, 60, 70};            add(tw, 12, 38);
        tw = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023}; add(tw, 5, 1023);

        got.delete(); got_cyc.delete();
        foreach (vt[v]) begin
            send(0, 0, 1'b1);
            for (int k = 0; k < 8; k++) send(vt[v].w[k], vt[v].frac, 1'b0);
        end
        wait_n(vt.size());
        repeat (5) @(negedge clk);
        check("vec_count", got.size(), vt.size());
        foreach (vt[v])
            if (v < got.size())
                check($sformatf("vec[%0d]_frac%0d", v, vt[v].frac), got[v], vt[v].exp);

        // Backpressure: out_ready low for 5 cycles mid-stream
        got.delete(); got_cyc.delete();
        fork
            begin
                send(0, 0, 1'b1);
                for (int i = 1; i <= 20; i++) send(i, 0, 1'b0);
            end
            begin
                wait_n(3);
                @(posedge clk); #1;
                out_ready = 1'b0;
                hold = int'(out_data);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check($sformatf("bp_in_ready[%0d]", c), int'(in_ready), 0);
                    check($sformatf("bp_out_valid[%0d]", c), int'(out_valid), 1);
                    check($sformatf("bp_hold[%0d]", c), int'(out_data), hold);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_n(13);
        repeat (5) @(negedge clk);
        check("bp_count", got.size(), 13);
        for (int i = 0; i < 13 && i < got.size(); i++)
            check($sformatf("bp_val[%0d]", i), got[i], 4 + i);

        // Line restart on the 12th sample
        got.delete(); got_cyc.delete();
        for (int i = 1; i <= 11; i++) send(100 + i, 0, 1'b0);
        send(200, 0, 1'b1);
        for (int i = 1; i <= 7; i++) send(200 + i, 0, 1'b0);
        repeat (8) @(negedge clk);
        check("sol_count_before", got.size(), 11);
        for (int i = 0; i < 11 && i < got.size(); i++)
            check($sformatf("sol_val[%0d]", i), got[i], (i < 4) ? 17 + i : 97 + i);
        send(208, 0, 1'b0);
        wait_n(12);
        if (got.size() >= 12) check("sol_first_new", got[11], 204);

        // Reset with 3 results in flight
        got.delete(); got_cyc.delete();
        for (int i = 0; i < 4; i++) send(300 + i, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_count", got.size(), 1);
        if (got.size() >= 1) check("rst_val0", got[0], 205);
        for (int i = 0; i < 7; i++) send(400 + i, 0, 1'b0);
        repeat (8) @(negedge clk);
        check("rst_refill_count", got.size(), 1);
        send(407, 0, 1'b0);
        wait_n(2);
        if (got.size() >= 2) check("rst_first_new", got[1], 403);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
